ram_stream_reader: RTL

Reads a contiguous range of words out of the single-port lab RAM and presents them on a valid/ready output stream, with full throughput and support for backpressure. It is the read side of the RAM interface: the test/write path fills the RAM through `addr`/`we`/`din`, and this block drives `addr` with write-enable held low, consuming `dout`. It sits between the RAM instance and any downstream consumer, such as a display, a UART transmitter or a checker.

---
 rtl/ram_stream_reader_pkg.sv | 12 +
 rtl/ram_stream_reader_skid_fifo2.sv | 47 ++++
 rtl/ram_stream_reader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for ram_stream_reader: controller state encoding and
// skid buffer depth.
package ram_stream_reader_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_stream_reader_skid_fifo2.sv
// skid_fifo2: two-entry synchronous FIFO holding RAM words (plus last flag)
// that could not be handed straight to the stream consumer.
module skid_fifo2
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'(FIFO_DEPTH));
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a contiguous (wrapping) range of RAM words onto a valid/ready port.
// Optional running checksum output enabled by RAM_STREAM_READER_CHECKSUM_EN.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int CW = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         sent_q, sent_d;
    logic                  done_q, done_d;
    logic                  dvalid_q, dlast_q;

    logic                  issue, issue_last, xfer;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;

    // dvalid_q marks a read word sitting on ram_dout; together with the FIFO
    // it never exceeds two outstanding words.
    assign issue      = (state_q == ST_RUN) && (issued_q < count_q) &&
                        (fifo_empty || (!fifo_full && !dvalid_q));
    assign issue_last = (issued_q == count_q - CW'(1));
    assign out_valid  = !fifo_empty || dvalid_q;
    assign xfer       = out_valid && out_ready;
    assign fifo_pop   = xfer && !fifo_empty;
    assign fifo_push  = dvalid_q && !(fifo_empty && out_ready);

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (!fifo_empty) begin
            out_last = fifo_head[DATA_WIDTH];
            out_data = fifo_head[DATA_WIDTH-1:0];
        end else if (dvalid_q) begin
            out_last = dlast_q;
            out_data = ram_dout;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d  = ST_RUN;
                        addr_d   = base_addr;
                        count_d  = count;
                        issued_d = '0;
                        sent_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + CW'(1);
                end
                if (xfer) begin
                    sent_d = sent_q + CW'(1);
                    if (sent_q == count_q - CW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            done_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            sent_q   <= sent_d;
            done_q   <= done_d;
            dvalid_q <= issue;
            dlast_q  <= issue && issue_last;
        end
    end

    skid_fifo2 #(.WIDTH(DATA_WIDTH + 1)) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .din_i   ({dlast_q, ram_dout}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ram_addr = addr_q;
    assign ram_we   = 1'b0;
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;

`ifdef RAM_STREAM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                               checksum_q <= '0;
        else if ((state_q == ST_IDLE) && start)  checksum_q <= '0;
        else if (xfer)                           checksum_q <= checksum_q + out_data;
    end

    assign checksum = checksum_q;
`endif

endmodule
